// File: rtl/acc_pkg.sv
// acc_pkg: shared opcode, flag and clear-FSM types for the accumulator bank.
package acc_pkg;

   localparam int unsigned FLAG_W = 4;

   typedef enum logic [2:0] {
      OP_NOP  = 3'b000,
      OP_LOAD = 3'b001,
      OP_ADD  = 3'b010,
      OP_SUB  = 3'b011,
      OP_SHL  = 3'b100,
      OP_SHR  = 3'b101,
      OP_PUSH = 3'b110,
      OP_POP  = 3'b111
   } acc_op_e;

   typedef struct packed {
      logic ovf;
      logic neg;
      logic carry;
      logic zero;
   } acc_flags_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } acc_state_e;

endpackage

// File: rtl/acc_lifo.sv
// acc_lifo: DEPTH-entry LIFO with combinational top-of-stack and registered full/empty.
module acc_lifo #(
   parameter int unsigned DATA_W = 12,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] top_c,
   output logic              full,
   output logic              empty
);
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (push && !full)
         cnt_d = cnt_q + CNT_W'(1);
      else if (pop && !empty)
         cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         cnt_q <= cnt_d;
         full  <= (cnt_d == CNT_W'(DEPTH));
         empty <= (cnt_d == '0);
      end
   end

   // Storage carries no reset; only entries below the count are ever read.
   always_ff @(posedge clk) begin
      if (push && !full)
         mem[ADDR_W'(cnt_q)] <= wdata;
   end

   assign top_c = mem[ADDR_W'(cnt_q - CNT_W'(1))];

endmodule

// File: rtl/acc_bank.sv
// acc_bank: NUM_ACC x WIDTH accumulator bank with ALU, registered flags and clear sweep.
// Shadow context stack is built only when ACC_BANK_STACK_EN is defined.
module acc_bank
   import acc_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned NUM_ACC     = 4,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       ce,
   input  logic [2:0]                 op,
   input  logic [$clog2(NUM_ACC)-1:0] sel,
   input  logic [WIDTH-1:0]           in_val,
   input  logic                       clr_all,
   output logic [WIDTH-1:0]           acc_out,
   output logic [3:0]                 flags,
   output logic                       stack_full,
   output logic                       stack_empty,
   output logic                       err,
   output logic                       busy
);
   localparam int unsigned SEL_W = $clog2(NUM_ACC);

   acc_state_e       state_q, state_d;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] acc_q [NUM_ACC];
   acc_flags_t       flags_q, flags_d;
   logic             err_q, err_d;
   logic             wr_acc, wr_flags, alu_op, accept;
   logic [WIDTH-1:0] cur, res;
   logic [WIDTH:0]   sum, diff;
   acc_op_e          op_e;

   assign op_e    = acc_op_e'(op);
   assign cur     = acc_q[sel];
   assign sum     = {1'b0, cur} + {1'b0, in_val};
   assign diff    = {1'b0, cur} - {1'b0, in_val};
   assign busy    = (state_q == ST_SWEEP);
   assign accept  = ce && !busy && !clr_all;
   assign acc_out = cur;
   assign flags   = flags_q;
   assign err     = err_q;

`ifdef ACC_BANK_STACK_EN
   localparam int unsigned ENT_W = WIDTH + FLAG_W;
   logic             push, pop;
   logic [ENT_W-1:0] top_c;

   acc_lifo #(.DATA_W(ENT_W), .DEPTH(STACK_DEPTH)) u_lifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .pop   (pop),
      .wdata ({cur, flags_q}),
      .top_c (top_c),
      .full  (stack_full),
      .empty (stack_empty)
   );
`else
   logic unused_stack_depth;
   assign unused_stack_depth = |STACK_DEPTH;
   assign stack_full         = 1'b0;
   assign stack_empty        = 1'b1;
`endif

   // Clear sequencer: state and sweep index registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (clr_all) begin
               state_d = ST_SWEEP;
               idx_d   = '0;
            end
         end
         ST_SWEEP: begin
            idx_d = idx_q + SEL_W'(1);
            if (idx_q == SEL_W'(NUM_ACC - 1))
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Command decode and ALU; a dropped or impossible command only raises err.
   always_comb begin
      res      = in_val;
      flags_d  = flags_q;
      wr_acc   = 1'b0;
      wr_flags = 1'b0;
      alu_op   = 1'b0;
      err_d    = ce && (busy || clr_all);
`ifdef ACC_BANK_STACK_EN
      push     = 1'b0;
      pop      = 1'b0;
`endif
      if (accept) begin
         case (op_e)
            OP_LOAD: begin
               alu_op        = 1'b1;
               res           = in_val;
               flags_d.carry = 1'b0;
               flags_d.ovf   = 1'b0;
            end
            OP_ADD: begin
               alu_op        = 1'b1;
               res           = sum[WIDTH-1:0];
               flags_d.carry = sum[WIDTH];
               flags_d.ovf   = (cur[WIDTH-1] == in_val[WIDTH-1]) && (sum[WIDTH-1] != cur[WIDTH-1]);
            end
            OP_SUB: begin
               alu_op        = 1'b1;
               res           = diff[WIDTH-1:0];
               flags_d.carry = diff[WIDTH];
               flags_d.ovf   = (cur[WIDTH-1] != in_val[WIDTH-1]) && (diff[WIDTH-1] != cur[WIDTH-1]);
            end
            OP_SHL: begin
               alu_op        = 1'b1;
               res           = {cur[WIDTH-2:0], 1'b0};
               flags_d.carry = cur[WIDTH-1];
               flags_d.ovf   = 1'b0;
            end
            OP_SHR: begin
               alu_op        = 1'b1;
               res           = {1'b0, cur[WIDTH-1:1]};
               flags_d.carry = cur[0];
               flags_d.ovf   = 1'b0;
            end
`ifdef ACC_BANK_STACK_EN
            OP_PUSH: begin
               if (stack_full) err_d = 1'b1;
               else            push  = 1'b1;
            end
            OP_POP: begin
               if (stack_empty) begin
                  err_d = 1'b1;
               end else begin
                  pop      = 1'b1;
                  res      = top_c[ENT_W-1:FLAG_W];
                  flags_d  = acc_flags_t'(top_c[FLAG_W-1:0]);
                  wr_acc   = 1'b1;
                  wr_flags = 1'b1;
               end
            end
`else
            OP_PUSH, OP_POP: err_d = 1'b1;
`endif
            default: ;
         endcase
      end
      if (alu_op) begin
         wr_acc       = 1'b1;
         wr_flags     = 1'b1;
         flags_d.neg  = res[WIDTH-1];
         flags_d.zero = (res == '0);
      end
   end

   // Accumulators, flags and error pulse; the sweep owns the bank while busy.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < NUM_ACC; i++)
            acc_q[SEL_W'(i)] <= '0;
         flags_q <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= err_d;
         if (busy) begin
            acc_q[idx_q] <= '0;
            if (idx_q == '0)
               flags_q <= '0;
         end else begin
            if (wr_acc)
               acc_q[sel] <= res;
            if (wr_flags)
               flags_q <= flags_d;
         end
      end
   end

endmodule

// File: tb/tb_acc_bank.sv
// tb_acc_bank: randomized self-checking bench for acc_bank against an arithmetic reference model.
module tb_acc_bank;
   localparam int W = 8;
   localparam int N = 4;
   localparam int D = 4;
`ifdef ACC_BANK_STACK_EN
   localparam bit STK_EN = 1'b1;
`else
   localparam bit STK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       ce = 1'b0;
   logic       clr_all = 1'b0;
   logic [2:0] op = 3'd0;
   logic [1:0] sel = 2'd0;
   logic [7:0] in_val = 8'd0;
   logic [7:0] acc_out;
   logic [3:0] flags;
   logic       stack_full, stack_empty, err, busy;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int          macc [N];
   logic [3:0]  mflags;
   logic [11:0] mstk [$];
   bit          exp_err;

   always #5 clk = ~clk;

   acc_bank #(.WIDTH(W), .NUM_ACC(N), .STACK_DEPTH(D)) dut (
      .clk(clk), .rstn(rstn), .ce(ce), .op(op), .sel(sel), .in_val(in_val),
      .clr_all(clr_all), .acc_out(acc_out), .flags(flags), .stack_full(stack_full),
      .stack_empty(stack_empty), .err(err), .busy(busy)
   );

   task automatic model_reset;
      for (int i = 0; i < N; i++) macc[i] = 0;
      mflags = 4'h0;
      mstk.delete();
      exp_err = 1'b0;
   endtask

   // Command semantics in plain integer arithmetic; flags = {ovf, neg, carry, zero}.
   task automatic model_cmd(input int o, input int s, input int v, output bit e);
      int a, r, sa, sv, sr;
      logic c, ov;
      logic [11:0] t;
      e  = 1'b0;
      a  = macc[s];
      sa = (a >= 128) ? a - 256 : a;
      sv = (v >= 128) ? v - 256 : v;
      r  = a; c = 1'b0; ov = 1'b0;
      case (o)
         1: r = v;
         2: begin r = a + v; c = (r > 255); r = r % 256; sr = sa + sv; ov = (sr > 127) || (sr < -128); end
         3: begin c = (v > a); r = (a - v + 256) % 256; sr = sa - sv; ov = (sr > 127) || (sr < -128); end
         4: begin c = (a >= 128); r = (a * 2) % 256; end
         5: begin c = (a % 2 == 1); r = a / 2; end
         6: begin
            if (!STK_EN || mstk.size() == D) e = 1'b1;
            else mstk.push_back({8'(a), mflags});
         end
         7: begin
            if (!STK_EN || mstk.size() == 0) e = 1'b1;
            else begin
               t = mstk.pop_back();
               macc[s] = int'(t[11:4]);
               mflags  = t[3:0];
            end
         end
         default: ;
      endcase
      if (o >= 1 && o <= 5) begin
         macc[s] = r;
         mflags  = {ov, (r >= 128), c, (r == 0)};
      end
   endtask

   function automatic logic [14:0] exp_vec(input int s);
      return {8'(macc[s]), mflags, exp_err, (STK_EN && mstk.size() == D), (!STK_EN || mstk.size() == 0)};
   endfunction

   task automatic do_cmd(input int o, input int s, input int v);
      bit e;
      ce = 1'b1; op = 3'(o); sel = 2'(s); in_val = 8'(v);
      @(posedge clk); #1;
      ce = 1'b0;
      model_cmd(o, s, v, e);
      exp_err = e;
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      #12;
      model_reset();
      checks++;
      if ({busy, err, flags, stack_full, stack_empty} !== {1'b0, 1'b0, 4'h0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_status: got %b want %b", {busy, err, flags, stack_full, stack_empty}, 8'b0000_0001);
      end
      for (int i = 0; i < N; i++) begin
         sel = 2'(i); #1;
         checks++;
         if (acc_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_acc%0d: got %h want 00", i, acc_out);
         end
      end
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_alu_vectors;
      int t_op  [10] = '{1, 2, 1, 3, 3, 1, 4, 5, 5, 0};
      int t_sel [10] = '{2, 2, 1, 1, 1, 0, 0, 0, 0, 3};
      int t_val [10] = '{'h7F, 'h01, 'h05, 'h06, 'hFF, 'h81, 0, 0, 0, 0};
      int t_acc [10] = '{'h7F, 'h80, 'h05, 'hFF, 'h00, 'h81, 'h02, 'h01, 'h00, 'h00};
      int t_flg [10] = '{'h0, 'hC, 'h0, 'h6, 'h1, 'h4, 'h2, 'h0, 'h3, 'h3};
      for (int i = 0; i < 10; i++) begin
         do_cmd(t_op[i], t_sel[i], t_val[i]);
         checks++;
         if ({acc_out, flags, err} !== {8'(t_acc[i]), 4'(t_flg[i]), 1'b0}) begin
            errors++;
            $display("FAIL alu_vec%0d: got acc=%h flags=%b err=%b want acc=%h flags=%b err=0",
                     i, acc_out, flags, err, 8'(t_acc[i]), 4'(t_flg[i]));
         end
      end
   endtask

   task automatic test_stack;
      int v [5] = '{'h90, 'h00, 'h7E, 'hC3, 'h55};
      logic [14:0] obs;
      for (int i = 0; i < 5; i++) begin
         do_cmd(1, i % N, v[i]);
         do_cmd(4, i % N, 0);
         do_cmd(6, i % N, 0);
         obs = {acc_out, flags, err, stack_full, stack_empty};
         checks++;
         if (obs !== exp_vec(i % N)) begin
            errors++;
            $display("FAIL push%0d: got %b want %b", i, obs, exp_vec(i % N));
         end
      end
      @(posedge clk); #1;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_one_cycle: got %b want 0", err);
      end
      do_cmd(1, 0, 'hAA);
      for (int i = 0; i < 5; i++) begin
         do_cmd(7, 0, 0);
         obs = {acc_out, flags, err, stack_full, stack_empty};
         checks++;
         if (obs !== exp_vec(0)) begin
            errors++;
            $display("FAIL pop%0d: got %b want %b", i, obs, exp_vec(0));
         end
      end
      checks++;
      if ({err, stack_empty} !== 2'b11) begin
         errors++;
         $display("FAIL pop_underflow: got err=%b empty=%b want 1 1", err, stack_empty);
      end
   endtask

   task automatic test_clear;
      int n;
      for (int i = 0; i < N; i++) do_cmd(1, i, 'h80 + 8 * i + 1);
      clr_all = 1'b1;
      @(posedge clk); #1;
      clr_all = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 20) begin
         if (n == 1) begin ce = 1'b1; op = 3'd1; sel = 2'd0; in_val = 8'h55; end
         @(posedge clk); #1;
         if (n == 0) begin
            checks++;
            if (flags !== 4'h0) begin errors++; $display("FAIL sweep_flags: got %b want 0000", flags); end
         end
         if (n == 1) begin
            ce = 1'b0;
            checks++;
            if (err !== 1'b1) begin errors++; $display("FAIL busy_err: got %b want 1", err); end
         end
         n++;
      end
      for (int i = 0; i < N; i++) macc[i] = 0;
      mflags = 4'h0;
      exp_err = 1'b0;
      checks++;
      if (n !== N) begin errors++; $display("FAIL busy_len: got %0d want %0d", n, N); end
      for (int i = 0; i < N; i++) begin
         sel = 2'(i); #1;
         checks++;
         if ({acc_out, flags, err, stack_full, stack_empty} !== exp_vec(i)) begin
            errors++;
            $display("FAIL clear_acc%0d: got %b want %b", i, {acc_out, flags, err, stack_full, stack_empty}, exp_vec(i));
         end
      end
      do_cmd(1, 2, 'h3C);
      checks++;
      if ({acc_out, err} !== {8'h3C, 1'b0}) begin
         errors++;
         $display("FAIL post_sweep_load: got acc=%h err=%b want 3c 0", acc_out, err);
      end
   endtask

   task automatic test_clr_conflict;
      int n;
      do_cmd(1, 1, 'h11);
      ce = 1'b1; op = 3'd1; sel = 2'd1; in_val = 8'h33; clr_all = 1'b1;
      @(posedge clk); #1;
      ce = 1'b0; clr_all = 1'b0;
      checks++;
      if ({err, busy} !== 2'b11) begin
         errors++;
         $display("FAIL clr_wins: got err=%b busy=%b want 1 1", err, busy);
      end
      n = 0;
      while (busy === 1'b1 && n < 20) begin
         clr_all = (n == 2);
         @(posedge clk); #1;
         n++;
      end
      clr_all = 1'b0;
      for (int i = 0; i < N; i++) macc[i] = 0;
      mflags = 4'h0;
      checks++;
      if (n !== N) begin errors++; $display("FAIL clr_busy_ignored: got %0d want %0d", n, N); end
      sel = 2'd1; #1;
      checks++;
      if (acc_out !== 8'h00) begin errors++; $display("FAIL clr_dropped_cmd: got %h want 00", acc_out); end
   endtask

   task automatic test_random;
      int o, s, v, r;
      logic [14:0] obs;
      for (int i = 0; i < 300; i++) begin
         o = int'($urandom_range(7, 0));
         s = int'($urandom_range(N - 1, 0));
         v = int'($urandom_range(255, 0));
         do_cmd(o, s, v);
         obs = {acc_out, flags, err, stack_full, stack_empty};
         checks++;
         if (obs !== exp_vec(s)) begin
            errors++;
            $display("FAIL rnd%0d op=%0d sel=%0d val=%h: got %b want %b", i, o, s, v, obs, exp_vec(s));
         end
         r = int'($urandom_range(N - 1, 0));
         sel = 2'(r); #1;
         checks++;
         if (acc_out !== 8'(macc[r])) begin
            errors++;
            $display("FAIL rnd_read%0d sel=%0d: got %h want %h", i, r, acc_out, 8'(macc[r]));
         end
      end
   endtask

   task automatic test_reset_mid_sweep;
      for (int i = 0; i < N; i++) do_cmd(1, i, 'hF0 + i);
      do_cmd(6, 0, 0);
      clr_all = 1'b1;
      @(posedge clk); #1;
      clr_all = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({busy, err, flags, stack_full, stack_empty} !== {1'b0, 1'b0, 4'h0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL midsweep_status: got %b want %b", {busy, err, flags, stack_full, stack_empty}, 8'b0000_0001);
      end
      for (int i = 0; i < N; i++) begin
         sel = 2'(i); #1;
         checks++;
         if (acc_out !== 8'h00) begin errors++; $display("FAIL midsweep_acc%0d: got %h want 00", i, acc_out); end
      end
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
      do_cmd(2, 3, 'h09);
      checks++;
      if ({acc_out, flags, err, stack_full, stack_empty} !== exp_vec(3)) begin
         errors++;
         $display("FAIL midsweep_recover: got %b want %b", {acc_out, flags, err, stack_full, stack_empty}, exp_vec(3));
      end
   endtask

   initial begin
      test_reset();
      test_alu_vectors();
      test_stack();
      test_clear();
      test_clr_conflict();
      test_random();
      test_reset_mid_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/acc_bank.md
# acc_bank

Parametrised accumulator bank for the Salamander datapath: NUM_ACC accumulators of WIDTH bits with an integrated ALU (load/add/sub/shift), registered status flags, a bank-wide clear sequencer, and an optional LIFO shadow stack for saving and restoring accumulator+flags context. It replaces the single load-only accumulator register. The bank sits between the operand bus (in_val) and the control unit, which drives op/sel/ce each cycle.

## Interface
- WIDTH, 8, accumulator and operand width (≥2)
- NUM_ACC, 4, number of accumulators (power of 2, ≥2)
- STACK_DEPTH, 4, shadow stack entries (≥1)
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- ce  in  1  command enable; op executes on the edge where ce=1 and busy=0
- op  in  3  operation code
- sel  in  $clog2(NUM_ACC)  target accumulator / read select
- in_val  in  WIDTH  operand
- clr_all  in  1  start bank-clear sweep
- acc_out  out  WIDTH  acc[sel], combinational read of registers
- flags  out  4  {ovf, neg, carry, zero}, registered
- stack_full  out  1  stack holds STACK_DEPTH entries
- stack_empty  out  1  stack holds 0 entries
- err  out  1  one-cycle pulse on rejected command
- busy  out  1  clear sweep in progress

## Operation
- Opcodes: 000 NOP, 001 LOAD (acc=in_val), 010 ADD (acc+in_val), 011 SUB (acc−in_val), 100 SHL (acc<<1, 0 in), 101 SHR (logical, 0 in), 110 PUSH, 111 POP; all act on acc[sel].
- Arithmetic is modulo 2^WIDTH; computed at WIDTH+1 bits.
- Flags update on LOAD/ADD/SUB/SHL/SHR only; NOP/PUSH leave them unchanged.
  - zero = result==0; neg = result[WIDTH-1].
  - carry: ADD carry-out; SUB borrow (1 when in_val > acc unsigned); SHL old MSB; SHR old LSB; LOAD 0.
  - ovf: signed overflow on ADD/SUB; 0 on LOAD/SHL/SHR.
- PUSH: writes {acc[sel], flags} at top, pointer+1. PUSH while full: no change, err=1.
- POP: acc[sel] and flags restored from top, pointer−1. POP while empty: no change, err=1.
- Clear FSM: IDLE, SWEEP. IDLE --clr_all--> SWEEP (idx=0). In SWEEP, each cycle zeroes acc[idx], idx+1; flags zeroed on first SWEEP cycle; SWEEP --idx==NUM_ACC-1--> IDLE. Stack untouched.
- busy = (state==SWEEP). ce=1 while busy: command dropped, err=1.
- clr_all and ce both high in IDLE: clr_all wins, command dropped, err=1. clr_all while busy: ignored.

## Timing
- Reset: all acc=0, flags=0, stack pointer=0, stack_empty=1, stack_full=0, err=0, busy=0, state IDLE. Reset mid-sweep aborts to IDLE with full reset values.
- All commands single-cycle: result visible on acc_out/flags the cycle after the accepting edge.
- acc_out follows sel combinationally with zero latency.
- stack_full/stack_empty registered, valid the cycle after PUSH/POP.
- err asserted the cycle after the rejecting edge, for exactly one cycle.
- Sweep: busy high for exactly NUM_ACC cycles starting the cycle after clr_all; first command accepted on the edge where busy returns low.

## Configuration
- ACC_BANK_STACK_EN defined: shadow stack built as above.
- Undefined: no stack storage; PUSH/POP act as NOP and pulse err; stack_empty tied 1, stack_full tied 0.

## Structure
- Package acc_pkg: acc_op_e (3-bit opcode enum), acc_flags_t (packed struct ovf/neg/carry/zero), acc_state_e (IDLE/SWEEP).
- Sub-module acc_lifo: parametrised LIFO (data width WIDTH+4, depth STACK_DEPTH) with push/pop/full/empty; instantiated only under ACC_BANK_STACK_EN.

## Test plan
- Reset then LOAD sel=2 in_val=0x7F; ADD in_val=0x01 -> acc_out=0x80, flags ovf=1 neg=1 carry=0 zero=0.
- LOAD 0x05; SUB 0x06 -> 0xFF, carry=1 neg=1; SUB 0xFF from 0xFF -> 0x00, zero=1 carry=0.
- LOAD 0x81; SHL -> 0x02 carry=1; SHR -> 0x01 carry=0.
- PUSH 4 values (stack_full=1), 5th PUSH -> err pulse, no change; 4 POPs restore values and flags in reverse order; 5th POP -> err, stack_empty=1.
- Load all 4 accs non-zero, clr_all -> busy high 4 cycles, all accs 0, flags 0; ce during busy -> err, accumulator unchanged.
- Assert rstn low during SWEEP cycle 2 -> busy=0, all outputs at reset values immediately.
